// File: rtl/rv_soc_ahb2apb_pkg.sv
// Shared encodings, FSM state type and request-decode helpers for the
// AHB3-Lite to APB4 bridge.
package rv_soc_ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  // Byte lanes touched by a write of the given size at the given offset.
  function automatic logic [3:0] gen_pstrb(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = 4'b0011 << addr;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Oversized or misaligned requests never reach the APB side.
  function automatic logic is_illegal(input logic [2:0] hsize, input logic [1:0] addr);
    logic bad;
    case (hsize)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr[0];
      HSIZE_WORD: bad = |addr;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rv_soc_ahb2apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge. One AHB transfer at a time is turned
// into an APB SETUP/ACCESS pair; APB errors, illegal requests and PREADY
// timeouts come back as two-cycle AHB ERROR responses.
module rv_soc_ahb2apb_bridge
  import rv_soc_ahb2apb_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                    HRESETn,
  input  logic                    HCLK,
  input  logic                    HSEL,
  input  logic [1:0]              HTRANS,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HWRITE,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  state_e                    state_q, state_d;
  logic                      psel_q, penable_q, hreadyout_q, hresp_q;
  logic [PADDR_SIZE-1:0]     paddr_q;
  logic                      pwrite_q;
  logic [2:0]                pprot_q;
  logic [PDATA_SIZE/8-1:0]   pstrb_q;
  logic [PDATA_SIZE-1:0]     pwdata_q;
  logic [HDATA_SIZE-1:0]     hrdata_q;
  logic                      trans_active;
  logic                      take;
  logic                      tmo_hit;

  // Burst type, lock, cacheability bits and upper address bits carry no
  // meaning on the APB side.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HADDR[HADDR_SIZE-1:PADDR_SIZE]};

  // Only NONSEQ/SEQ beats request work; every beat is handled independently.
  always_comb begin
    trans_active = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
    endcase
  end

  assign take = HSEL & HREADY & trans_active &
                ((state_q == ST_IDLE) || (state_q == ST_ERR2));

  // Next-state decode; ERR2 accepts a new request exactly like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (!take)                                state_d = ST_IDLE;
        else if (is_illegal(HSIZE, HADDR[1:0]))   state_d = ST_ERR1;
        else if (HWRITE)                          state_d = ST_WLATCH;
        else                                      state_d = ST_SETUP;
      end
      ST_WLATCH: state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)       state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
        else if (tmo_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State plus bus handshake outputs, registered from the next state so they
  // change glitch-free on the clock edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q   <= (state_d == ST_ACCESS);
      hreadyout_q <= (state_d == ST_IDLE) || (state_d == ST_ERR2);
      hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end
  end

  // Capture the address phase at accept; held until the next accept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
    end else if (take) begin
      paddr_q  <= HADDR[PADDR_SIZE-1:0];
      pwrite_q <= HWRITE;
      pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
      pstrb_q  <= HWRITE ? gen_pstrb(HSIZE, HADDR[1:0]) : '0;
    end
  end

  // Write data arrives in the AHB data phase, which is the WLATCH cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                  pwdata_q <= '0;
    else if (state_q == ST_WLATCH) pwdata_q <= HWDATA;
  end

  // Read data updates only on a successful read completion, otherwise holds.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      hrdata_q <= '0;
    else if ((state_q == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_q)
      hrdata_q <= PRDATA;
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] tmo_cnt_q;

      // Counts stalled ACCESS cycles; saturates rather than wrapping.
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
          tmo_cnt_q <= '0;
        else if (state_q == ST_SETUP)
          tmo_cnt_q <= '0;
        else if ((state_q == ST_ACCESS) && !PREADY && (tmo_cnt_q != CNT_W'(TIMEOUT)))
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      // Fires in the stalled cycle that brings the count up to TIMEOUT.
      assign tmo_hit = (state_q == ST_ACCESS) && !PREADY &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PPROT     = pprot_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_rv_soc_ahb2apb_bridge.sv
// Directed bench for the AHB-to-APB bridge. Expected completions (latency,
// response, read data) are queued when a request is driven and compared
// when HREADYOUT returns high.
module tb_rv_soc_ahb2apb_bridge;

  logic        HRESETn, HCLK;
  logic        HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADYOUT, HRESP;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  rv_soc_ahb2apb_bridge #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(8), .PDATA_SIZE(32), .TIMEOUT(4)
  ) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE),
    .PPROT(PPROT), .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HPROT = '0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [3:0] prot, input logic [31:0] rd,
                       input logic resp, input int lat);
    exp_t e;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; HPROT = prot;
    PRDATA = rd;
    if (!wr && !resp) last_rd = rd;
    e.resp = resp; e.rdata = last_rd; e.lat = lat;
    sb.push_back(e);
  endtask

  // n0 = cycles already elapsed since the accept cycle at the current sample.
  task automatic finish_xfer(input string tag, input int n0);
    exp_t e;
    int   n;
    n = n0;
    while (HREADYOUT !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    e.resp = 1'bx; e.rdata = 'x; e.lat = -1;
    if (sb.size() != 0) e = sb.pop_front();
    check({tag, "_latency"}, n, e.lat);
    check({tag, "_hresp"}, HRESP, e.resp);
    check({tag, "_hrdata"}, HRDATA, e.rdata);
  endtask

  task automatic check_reset(input string p);
    check({p, "_hreadyout"}, HREADYOUT, 1);
    check({p, "_hresp"}, HRESP, 0);
    check({p, "_hrdata"}, HRDATA, 0);
    check({p, "_psel"}, PSEL, 0);
    check({p, "_penable"}, PENABLE, 0);
    check({p, "_pwrite"}, PWRITE, 0);
    check({p, "_pstrb"}, PSTRB, 0);
    check({p, "_pprot"}, PPROT, 0);
    check({p, "_paddr"}, PADDR, 0);
    check({p, "_pwdata"}, PWDATA, 0);
  endtask

  initial begin
    int n;
    int pen;
    HRESETn = 1'b0; HBURST = '0; HMASTLOCK = 1'b0; HREADY = 1'b1; HWDATA = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0; last_rd = '0;
    bus_idle();
    tick(); tick();
    check_reset("rst");
    HRESETn = 1'b1;
    tick();

    // Word read, zero wait states.
    issue(1'b0, 32'h80, 3'b010, 4'b0011, 32'hDEADBEEF, 1'b0, 3);
    tick(); bus_idle();
    check("rd_setup_psel", PSEL, 1);
    check("rd_setup_penable", PENABLE, 0);
    check("rd_setup_hready", HREADYOUT, 0);
    check("rd_paddr", PADDR, 8'h80);
    check("rd_pstrb", PSTRB, 4'b0000);
    check("rd_pwrite", PWRITE, 0);
    check("rd_pprot", PPROT, 3'b001);
    tick();
    check("rd_access_psel", PSEL, 1);
    check("rd_access_penable", PENABLE, 1);
    finish_xfer("rd80", 2);
    check("rd_done_psel", PSEL, 0);

    // Byte write to 0x43, accepted back-to-back in the completing cycle.
    issue(1'b1, 32'h43, 3'b000, 4'b0000, 32'h0, 1'b0, 4);
    tick(); bus_idle(); HWDATA = 32'h11223344;
    check("wr_wlatch_psel", PSEL, 0);
    check("wr_wlatch_hready", HREADYOUT, 0);
    tick(); HWDATA = 32'hBADBAD00;
    check("wr_setup_psel", PSEL, 1);
    check("wr_pstrb", PSTRB, 4'b1000);
    check("wr_paddr", PADDR, 8'h43);
    check("wr_pwrite", PWRITE, 1);
    check("wr_pwdata", PWDATA, 32'h11223344);
    check("wr_pprot", PPROT, 3'b100);
    finish_xfer("wr43", 2);

    // Read with three APB wait states.
    PREADY = 1'b0;
    issue(1'b0, 32'h10, 3'b010, 4'b0001, 32'hCAFEF00D, 1'b0, 6);
    tick(); bus_idle();
    tick();
    check("ws_hrdata_hold", HRDATA, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws_penable%0d", i), PENABLE, 1);
      check($sformatf("ws_paddr%0d", i), PADDR, 8'h10);
      check($sformatf("ws_pstrb%0d", i), PSTRB, 4'b0000);
      check($sformatf("ws_hready%0d", i), HREADYOUT, 0);
      if (i == 3) PREADY = 1'b1;
      tick();
    end
    finish_xfer("ws_read", 6);

    // PSLVERR on a write, then a read accepted during ERR2.
    PSLVERR = 1'b1;
    issue(1'b1, 32'h08, 3'b010, 4'b0010, 32'h0, 1'b1, 5);
    tick(); bus_idle(); HWDATA = 32'h55AA55AA;
    tick();
    tick();
    check("slverr_penable", PENABLE, 1);
    check("slverr_pwdata", PWDATA, 32'h55AA55AA);
    tick();
    check("err1_hresp", HRESP, 1);
    check("err1_hready", HREADYOUT, 0);
    check("err1_psel", PSEL, 0);
    PSLVERR = 1'b0;
    finish_xfer("slverr_write", 4);
    issue(1'b0, 32'h0C, 3'b010, 4'b0001, 32'h0BADF00D, 1'b0, 3);
    tick(); bus_idle();
    check("err2_accept_psel", PSEL, 1);
    check("err2_accept_hresp", HRESP, 0);
    finish_xfer("err2_read", 1);

    // Halfword write at offset 2.
    issue(1'b1, 32'h02, 3'b001, 4'b0011, 32'h0, 1'b0, 4);
    tick(); bus_idle(); HWDATA = 32'hA5A50000;
    tick();
    check("hw_pstrb", PSTRB, 4'b1100);
    check("hw_pprot", PPROT, 3'b001);
    finish_xfer("hw_write", 2);

    // Illegal requests: misaligned halfword, oversized, misaligned word.
    issue(1'b0, 32'h01, 3'b001, 4'b0000, 32'h0, 1'b1, 2);
    tick(); bus_idle();
    check("ill_half_psel", PSEL, 0);
    check("ill_half_hresp", HRESP, 1);
    check("ill_half_hready", HREADYOUT, 0);
    finish_xfer("ill_half", 1);
    issue(1'b1, 32'h00, 3'b011, 4'b0000, 32'h0, 1'b1, 2);
    tick(); bus_idle();
    check("ill_size_psel", PSEL, 0);
    finish_xfer("ill_size", 1);
    issue(1'b0, 32'h06, 3'b010, 4'b0000, 32'h0, 1'b1, 2);
    tick(); bus_idle();
    check("ill_word_psel", PSEL, 0);
    finish_xfer("ill_word", 1);
    tick();
    check("post_err_hresp", HRESP, 0);
    check("post_err_hready", HREADYOUT, 1);

    // BUSY beats and deselected NONSEQ are ignored.
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h44; HWRITE = 1'b1; HSIZE = 3'b010;
    tick();
    check("busy_psel", PSEL, 0);
    check("busy_hready", HREADYOUT, 1);
    check("busy_hresp", HRESP, 0);
    HSEL = 1'b0; HTRANS = 2'b10;
    tick();
    check("nosel_psel", PSEL, 0);
    check("nosel_hready", HREADYOUT, 1);
    bus_idle();

    // PREADY stuck low: timeout after four ACCESS cycles.
    PREADY = 1'b0;
    issue(1'b0, 32'h20, 3'b010, 4'b0000, 32'h77777777, 1'b1, 7);
    tick(); bus_idle();
    n = 1; pen = 0;
    while (PSEL === 1'b1 && n < 20) begin
      if (PENABLE === 1'b1) pen++;
      tick();
      n++;
    end
    check("tmo_access_cycles", pen, 4);
    check("tmo_err1_hresp", HRESP, 1);
    check("tmo_err1_hready", HREADYOUT, 0);
    PREADY = 1'b1;
    finish_xfer("tmo", n);

    // Reset in the middle of an ACCESS aborts everything at once.
    PREADY = 1'b0;
    issue(1'b1, 32'h30, 3'b010, 4'b0000, 32'h0, 1'b0, 4);
    tick(); bus_idle(); HWDATA = 32'h12345678;
    tick(); tick();
    check("pre_rst_penable", PENABLE, 1);
    HRESETn = 1'b0;
    #1;
    check_reset("midrst");
    sb.delete();
    last_rd = '0;
    tick();
    HRESETn = 1'b1; PREADY = 1'b1;
    tick();
    issue(1'b0, 32'h04, 3'b010, 4'b0000, 32'h600DCAFE, 1'b0, 3);
    tick(); bus_idle();
    finish_xfer("post_rst_read", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
